mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Two-requester round-robin arbiter that owns the `Selector` of the 2:1 word multiplexer and shares it between two valid/ready producers. It grants one channel at a time, steers that channel's data through the mux into a one-entry registered output stage, and bounds each grant to `MAX_BURST` beats so neither producer can starve the other. It sits between two producer pipelines and a single downstream consumer.

## Interface
- `WORD_LENGHT`, 8, data width of both channels and the output.
- `MAX_BURST`, 4, maximum beats accepted per grant before re-arbitration (≥1).
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `Req_Valid_0` / `Req_Valid_1` input 1: channel 0 / 1 has a beat.
- `Req_Data_0` / `Req_Data_1` input WORD_LENGHT: channel 0 / 1 payload.
- `Req_Ready_0` / `Req_Ready_1` output 1: channel 0 / 1 beat accepted this cycle when valid.
- `Out_Valid` output 1: output register holds a beat.
- `Out_Data` output WORD_LENGHT: output register contents.
- `Out_Ready` input 1: consumer accepts `Out_Data` this cycle.
- `Selector` output 1: mux select / current or most recent grant (0 = channel 0).
- `Busy` output 1: FSM is not in IDLE.

## Operation
- FSM states: IDLE, GRANT_0, GRANT_1. Registers: `Prio` (preferred channel on a tie), `Beat_Count` (0..MAX_BURST-1), output register.
- Ready rule: `Req_Ready_i = (state == GRANT_i) && (!Out_Valid || Out_Ready)`. Combinational, no dependence on `Req_Valid_i`.
- Accept: `Req_Valid_i && Req_Ready_i` loads `Req_Data_i` (through the mux, `Selector = i`) into `Out_Data`, sets `Out_Valid`, increments `Beat_Count`.
- `Out_Valid` clears on `Out_Ready` with no accept in the same cycle. Accept and drain in the same cycle replace the contents; `Out_Valid` stays 1.
- Winner selection: only one valid → that one. Both valid → `Prio`. On entry to GRANT_w: `Selector = w`, `Prio = ~w`, `Beat_Count = 0`.
- IDLE: any valid → GRANT_winner next cycle. No valid → stay.
- GRANT_i exits (re-arbitrate) when either condition holds:
  - `Req_Valid_i` is low in a cycle where `Req_Ready_i` would be 1.
  - An accept brings `Beat_Count` to MAX_BURST.
- On exit: winner among the current valids, with `Prio` already flipped. If i is the sole requester, re-enter GRANT_i with the count cleared. No valid → IDLE.
- `Selector` holds its value in IDLE. It changes only on grant entry.
- Backpressure (`Out_Ready` low, `Out_Valid` high) freezes the FSM and count. Valid dropping during backpressure does not end the grant.

## Timing
- Reset values: state IDLE, `Out_Valid` 0, `Out_Data` 0, `Selector` 0, `Busy` 0, `Req_Ready_*` 0, `Prio` 0, `Beat_Count` 0.
- Arbitration latency: a request arriving in IDLE at cycle n is granted at n+1. Its first `Req_Ready` is also at n+1.
- Data latency: a beat accepted at edge n appears on `Out_Data`/`Out_Valid` after edge n (1 cycle).
- Throughput: 1 beat/cycle while the grant persists and the consumer is ready. A handover between channels costs no bubble when the exit is caused by the burst limit; a valid-drop exit costs 1 cycle.
- Reset mid-burst: everything returns to reset values immediately. A beat held in the output register is discarded.

## Configuration
- `MUX_ARB_FIXED_PRIO_EN` defined: ties always go to channel 0, and `Prio` is ignored. The burst limit still forces re-arbitration, so channel 1 is granted only when channel 0 is not valid.
- Not defined: round-robin as described above.

## Test plan
- Reset: assert `reset`=0 mid-burst with `Out_Valid`=1 → all outputs 0 asynchronously, before the next edge. After release with no valids, IDLE is held and `Busy`=0.
- Single channel: `Req_Valid_0`=1 streaming 0x10..0x15, `Out_Ready`=1, MAX_BURST=4.
  - Grant starts 1 cycle after the request.
  - 0x10–0x13 accepted back-to-back, then the grant re-enters GRANT_0 with no gap.
  - All 6 beats appear in order on `Out_Data`, 1 cycle after each accept.
- Contention: both channels valid continuously (ch0 0xA0.., ch1 0xB0..) from reset → `Out_Data` sequence is 0xA0–0xA3, 0xB0–0xB3, 0xA4–0xA7. `Selector` toggles 0→1→0 at the grant boundaries.
- Backpressure: `Out_Ready`=0 for 3 cycles with `Out_Valid`=1.
  - `Req_Ready_*` stays 0, and `Out_Data` and `Beat_Count` are stable.
  - After release, the next beat is accepted in the same cycle the held beat drains.
- Valid drop: ch1 valid for 2 beats then low, ch0 valid → GRANT_1 exits after the drop cycle and GRANT_0 follows. `Selector` stays 1 through IDLE if ch0 is absent.
- Macro: with `MUX_ARB_FIXED_PRIO_EN` and both channels continuously valid, only channel-0 beats are output. Once ch0 goes idle, channel 1 is granted.

Source files
------------

// File: rtl/mux_rr_arbiter_if.sv
// Two producer channels, the registered output stage and arbiter status of mux_rr_arbiter.
// master = arbiter side, slave = producers/consumer side.
interface mux_rr_arbiter_if #(
    parameter int WORD_LENGHT = 8
);
    logic                   Req_Valid_0;
    logic                   Req_Valid_1;
    logic [WORD_LENGHT-1:0] Req_Data_0;
    logic [WORD_LENGHT-1:0] Req_Data_1;
    logic                   Req_Ready_0;
    logic                   Req_Ready_1;
    logic                   Out_Valid;
    logic [WORD_LENGHT-1:0] Out_Data;
    logic                   Out_Ready;
    logic                   Selector;
    logic                   Busy;

    modport master (
        input  Req_Valid_0, Req_Valid_1, Req_Data_0, Req_Data_1, Out_Ready,
        output Req_Ready_0, Req_Ready_1, Out_Valid, Out_Data, Selector, Busy
    );

    modport slave (
        output Req_Valid_0, Req_Valid_1, Req_Data_0, Req_Data_1, Out_Ready,
        input  Req_Ready_0, Req_Ready_1, Out_Valid, Out_Data, Selector, Busy
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin 2:1 arbiter with bursts of up to MAX_BURST beats; MUX_ARB_FIXED_PRIO_EN gives ties to ch0.
// Latency: grant 1 cycle after request in IDLE, data 1 cycle after accept (registered output).
// Backpressure: Req_Ready only when the output register is empty or draining; FSM and count freeze otherwise.
module mux_rr_arbiter #(
    parameter int WORD_LENGHT = 8,
    parameter int MAX_BURST   = 4
) (
    input  logic               clk,
    input  logic               reset,
    mux_rr_arbiter_if.master   bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_0 = 2'd1;
    localparam logic [1:0] GRANT_1 = 2'd2;

    localparam int            CW        = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    logic [1:0]             state, state_nxt;
    logic                   prio, prio_nxt;
    logic                   selector, selector_nxt;
    logic [CW-1:0]          beat_count, beat_count_nxt;
    logic                   out_valid;
    logic [WORD_LENGHT-1:0] out_data;
    logic [WORD_LENGHT-1:0] mux_data;
    logic                   can_move, ready_0, ready_1, accept;
    logic                   cur_valid, any_valid, winner, enter;

    assign can_move  = !out_valid || bus.Out_Ready;
    assign ready_0   = (state == GRANT_0) && can_move;
    assign ready_1   = (state == GRANT_1) && can_move;
    assign accept    = (bus.Req_Valid_0 && ready_0) || (bus.Req_Valid_1 && ready_1);
    assign mux_data  = selector ? bus.Req_Data_1 : bus.Req_Data_0;
    // selector always equals the granted channel while in a GRANT state
    assign cur_valid = selector ? bus.Req_Valid_1 : bus.Req_Valid_0;
    assign any_valid = bus.Req_Valid_0 || bus.Req_Valid_1;

`ifdef MUX_ARB_FIXED_PRIO_EN
    assign winner = !bus.Req_Valid_0;
`else
    assign winner = (bus.Req_Valid_0 && bus.Req_Valid_1) ? prio : bus.Req_Valid_1;
`endif

    always_comb begin
        state_nxt      = state;
        prio_nxt       = prio;
        selector_nxt   = selector;
        beat_count_nxt = beat_count;
        enter          = 1'b0;
        case (state)
            IDLE: begin
                enter = any_valid;
            end
            GRANT_0, GRANT_1: begin
                if (can_move) begin
                    // a valid-drop or the last beat of the burst ends the grant
                    if (!cur_valid || (beat_count == LAST_BEAT)) begin
                        if (any_valid) begin
                            enter = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        beat_count_nxt = beat_count + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (enter) begin
            state_nxt      = winner ? GRANT_1 : GRANT_0;
            selector_nxt   = winner;
            prio_nxt       = !winner;
            beat_count_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            prio       <= 1'b0;
            selector   <= 1'b0;
            beat_count <= '0;
        end else begin
            state      <= state_nxt;
            prio       <= prio_nxt;
            selector   <= selector_nxt;
            beat_count <= beat_count_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
        end else if (bus.Out_Ready) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.Req_Ready_0 = ready_0;
    assign bus.Req_Ready_1 = ready_1;
    assign bus.Out_Valid   = out_valid;
    assign bus.Out_Data    = out_data;
    assign bus.Selector    = selector;
    assign bus.Busy        = (state != IDLE);
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: a per-cycle vector table plus contention and mid-burst reset sequences.
module tb_mux_rr_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mux_rr_arbiter_if #(.WORD_LENGHT(8)) bus ();

    mux_rr_arbiter #(.WORD_LENGHT(8), .MAX_BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       ordy;
        logic       r0;
        logic       r1;
        logic       ov;
        logic [7:0] od;
        logic       sel;
        logic       busy;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic v0, input logic [7:0] d0, input logic v1,
                                input logic [7:0] d1, input logic ordy, input logic r0,
                                input logic r1, input logic ov, input logic [7:0] od,
                                input logic sel, input logic busy);
        vec_t v;
        v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.ordy = ordy;
        v.r0 = r0; v.r1 = r1; v.ov = ov; v.od = od; v.sel = sel; v.busy = busy;
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] outs();
        return {bus.Req_Ready_0, bus.Req_Ready_1, bus.Out_Valid, bus.Out_Data,
                bus.Selector, bus.Busy};
    endfunction

    task automatic drive(input logic v0, input logic [7:0] d0, input logic v1,
                         input logic [7:0] d1, input logic ordy);
        bus.Req_Valid_0 = v0;
        bus.Req_Data_0  = d0;
        bus.Req_Valid_1 = v1;
        bus.Req_Data_1  = d1;
        bus.Out_Ready   = ordy;
    endtask

    logic [7:0] exp_beats[12];
    logic [7:0] got_beats[$];
    logic       exp_sel5;
    int         n0, n1;

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        //    v0 d0     v1 d1     ordy | r0 r1 ov od     sel busy
        add(1, 8'h10, 0, 8'h00, 1,   0, 0, 0, 8'h00, 0, 0);
        add(1, 8'h10, 0, 8'h00, 1,   1, 0, 0, 8'h00, 0, 1);
        add(1, 8'h11, 0, 8'h00, 1,   1, 0, 1, 8'h10, 0, 1);
        add(1, 8'h12, 0, 8'h00, 1,   1, 0, 1, 8'h11, 0, 1);
        add(1, 8'h13, 0, 8'h00, 1,   1, 0, 1, 8'h12, 0, 1);
        add(1, 8'h14, 0, 8'h00, 1,   1, 0, 1, 8'h13, 0, 1);
        add(1, 8'h15, 0, 8'h00, 1,   1, 0, 1, 8'h14, 0, 1);
        add(0, 8'h00, 0, 8'h00, 1,   1, 0, 1, 8'h15, 0, 1);
        add(0, 8'h00, 0, 8'h00, 1,   0, 0, 0, 8'h15, 0, 0);
        add(1, 8'h20, 0, 8'h00, 1,   0, 0, 0, 8'h15, 0, 0);
        add(1, 8'h20, 0, 8'h00, 0,   1, 0, 0, 8'h15, 0, 1);
        add(1, 8'h21, 0, 8'h00, 0,   0, 0, 1, 8'h20, 0, 1);
        add(1, 8'h21, 0, 8'h00, 0,   0, 0, 1, 8'h20, 0, 1);
        add(0, 8'h21, 0, 8'h00, 0,   0, 0, 1, 8'h20, 0, 1);
        add(1, 8'h21, 0, 8'h00, 1,   1, 0, 1, 8'h20, 0, 1);
        add(1, 8'h22, 0, 8'h00, 1,   1, 0, 1, 8'h21, 0, 1);
        add(0, 8'h00, 1, 8'h30, 1,   1, 0, 1, 8'h22, 0, 1);
        add(0, 8'h00, 1, 8'h30, 1,   0, 1, 0, 8'h22, 1, 1);
        add(0, 8'h00, 1, 8'h31, 1,   0, 1, 1, 8'h30, 1, 1);
        add(0, 8'h00, 0, 8'h00, 1,   0, 1, 1, 8'h31, 1, 1);
        add(0, 8'h00, 0, 8'h00, 1,   0, 0, 0, 8'h31, 1, 0);
        add(0, 8'h00, 0, 8'h00, 1,   0, 0, 0, 8'h31, 1, 0);
        add(1, 8'h40, 1, 8'h32, 1,   0, 0, 0, 8'h31, 1, 0);
        add(1, 8'h40, 1, 8'h32, 1,   1, 0, 0, 8'h31, 0, 1);
        add(1, 8'h41, 1, 8'h32, 1,   1, 0, 1, 8'h40, 0, 1);
        add(0, 8'h00, 0, 8'h00, 1,   1, 0, 1, 8'h41, 0, 1);

        #3;
        check("reset_state", 32'(outs()), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        foreach (vq[i]) begin
            drive(vq[i].v0, vq[i].d0, vq[i].v1, vq[i].d1, vq[i].ordy);
            @(negedge clk);
            check($sformatf("vec%0d", i), 32'(outs()),
                  32'({vq[i].r0, vq[i].r1, vq[i].ov, vq[i].od, vq[i].sel, vq[i].busy}));
            @(posedge clk); #1;
        end

        // Contention: both producers always valid, each advancing on its own accept.
`ifdef MUX_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 12; k++) exp_beats[k] = 8'hA0 + 8'(k);
        exp_sel5 = 1'b0;
`else
        for (int k = 0; k < 4; k++) begin
            exp_beats[k]     = 8'hA0 + 8'(k);
            exp_beats[k + 4] = 8'hB0 + 8'(k);
            exp_beats[k + 8] = 8'hA4 + 8'(k);
        end
        exp_sel5 = 1'b1;
`endif
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 14; c++) begin
            drive(1'b1, 8'hA0 + 8'(n0), 1'b1, 8'hB0 + 8'(n1), 1'b1);
            @(negedge clk);
            if (bus.Out_Valid && bus.Out_Ready) got_beats.push_back(bus.Out_Data);
            if (bus.Req_Ready_0) n0++;
            if (bus.Req_Ready_1) n1++;
            if (c == 5) check("contend_sel_c5", 32'(bus.Selector), 32'(exp_sel5));
            if (c == 9) check("contend_sel_c9", 32'(bus.Selector), 32'd0);
            if (c < 13) begin
                @(posedge clk); #1;
            end
        end
        check("contend_beat_count", 32'(got_beats.size()), 32'd12);
        foreach (got_beats[k]) begin
            if (k < 12) check($sformatf("contend_beat%0d", k), 32'(got_beats[k]), 32'(exp_beats[k]));
        end

        // Asynchronous reset with a beat held in the output register.
        check("midburst_out_valid", 32'(bus.Out_Valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", 32'(outs()), 32'd0);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", 32'(outs()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
